// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg
//   Shared definitions for the RXD receiver on the SOC IO page:
//   - receiver FSM state encoding
//   - IO read-mux word-address bit indices for the RX data and status words
//   - default bit period (100 MHz / 115200 baud)
//   - helper that packs the RX status word for the IO read mux
// Optional build macro: UART_RX_PARITY_EN adds the PARITY state (8E1 framing).
package uart_rx_fifo_pkg;

  localparam int UART_RX_CLKS_PER_BIT_DEF = 868;

  // Word-address one-hot bit indices, continuing after the transmitter's IO_* entries.
  localparam int IO_UART_RX_DAT  = 6;
  localparam int IO_UART_RX_STAT = 7;

  // Status word bit positions.
  localparam int RX_STAT_VALID_BIT = 0;
  localparam int RX_STAT_OVR_BIT   = 1;
  localparam int RX_STAT_FERR_BIT  = 2;
  localparam int RX_STAT_CNT_LSB   = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3
`ifdef UART_RX_PARITY_EN
    , ST_PARITY = 3'd4
`endif
  } rx_state_e;

  // Status word: [0] rx_valid, [1] overrun, [2] frame_err, [15:8] rx_count.
  function automatic logic [15:0] pack_rx_stat(input logic       valid,
                                               input logic       ovr,
                                               input logic       ferr,
                                               input logic [7:0] count);
    logic [15:0] w;
    w = '0;
    w[RX_STAT_VALID_BIT] = valid;
    w[RX_STAT_OVR_BIT]   = ovr;
    w[RX_STAT_FERR_BIT]  = ferr;
    w[RX_STAT_CNT_LSB +: 8] = count;
    return w;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// sync_fifo
//   Generic first-word-fall-through FIFO. Head word is presented on rdata_o
//   combinationally and reads as 0 while empty.
//   Ports: clk_i, rst_ni (async active-low), push_i/wdata_i write side,
//          pop_i read side, rdata_o head word, full_o, empty_o, count_o.
//   Push while full is accepted only when a pop happens in the same cycle;
//   pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   count_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic                push_ok, pop_ok;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                   (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;

  assign pop_ok  = pop_i & ~empty_o;
  // When full, a same-cycle pop frees the slot the push lands in.
  assign push_ok = push_i & (~full_o | pop_ok);

  assign wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   UART receiver (115200 8N1 by default) with an 8-bit FWFT receive FIFO.
//   Ports: clk, resetn (async active-low), rxd (async serial line, idle high),
//          rd_strb (pop head), clr_err (clear sticky errors),
//          rd_data (head byte, 0 when empty), rx_valid, rx_count,
//          overrun, frame_err (sticky), busy (FSM not idle),
//          parity_err (sticky, only with UART_RX_PARITY_EN).
//   Optional build macro: UART_RX_PARITY_EN selects 8E1 framing.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   IDLE     | line idle, waiting for a falling edge
//   START    | half-bit wait, confirm start bit still low
//   DATA     | sample 8 data bits at bit centre, LSB first
//   PARITY   | sample even-parity bit (UART_RX_PARITY_EN only)
//   STOP     | sample stop bit; on low, hold here until the line recovers
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int CLKS_PER_BIT    = UART_RX_CLKS_PER_BIT_DEF,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     rxd,
  input  logic                     rd_strb,
  input  logic                     clr_err,
  output logic [7:0]               rd_data,
  output logic                     rx_valid,
  output logic [FIFO_DEPTH_LOG2:0] rx_count,
  output logic                     overrun,
  output logic                     frame_err,
  output logic                     busy
`ifdef UART_RX_PARITY_EN
  , output logic                   parity_err
`endif
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

  logic rxd_s1_q, rxd_s2_q, rxs_prev_q;
  logic rxs;

  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          brk_q, brk_d;
  logic          tick;
  logic          push, frame_set;
  logic          overrun_q, overrun_d;
  logic          frame_err_q, frame_err_d;
  logic          fifo_full, fifo_empty;
`ifdef UART_RX_PARITY_EN
  logic          par_bad_q, par_bad_d;
  logic          par_set;
  logic          parity_err_q, parity_err_d;
`endif

  assign rxs  = rxd_s2_q;
  assign tick = (cnt_q == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rxd_s1_q   <= rxd;
      rxd_s2_q   <= rxd_s1_q;
      rxs_prev_q <= rxd_s2_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    brk_d     = brk_q;
    push      = 1'b0;
    frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    par_set   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rxs_prev_q && !rxs) begin
          state_d = ST_START;
          cnt_d   = HALF_LOAD;
`ifdef UART_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      ST_START: begin
        if (tick) begin
          if (!rxs) begin
            state_d   = ST_DATA;
            bit_idx_d = 3'd0;
            cnt_d     = FULL_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = {rxs, shift_q[7:1]};
          cnt_d   = FULL_LOAD;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          // Even parity: data bits XOR parity bit must be 0.
          par_bad_d = (^shift_q) ^ rxs;
          par_set   = par_bad_d;
          cnt_d     = FULL_LOAD;
          state_d   = ST_STOP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (brk_q) begin
          // Leave only once the line is high again, so a break cannot retrigger.
          if (rxs) begin
            brk_d   = 1'b0;
            state_d = ST_IDLE;
          end
        end else if (tick) begin
          if (rxs) begin
`ifdef UART_RX_PARITY_EN
            push = ~par_bad_q;
`else
            push = 1'b1;
`endif
            state_d = ST_IDLE;
          end else begin
            frame_set = 1'b1;
            brk_d     = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky errors: a set in the same cycle as clr_err wins.
  assign overrun_d   = (push & fifo_full & ~rd_strb) | (overrun_q & ~clr_err);
  assign frame_err_d = frame_set | (frame_err_q & ~clr_err);
`ifdef UART_RX_PARITY_EN
  assign parity_err_d = par_set | (parity_err_q & ~clr_err);
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      brk_q       <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      brk_q       <= brk_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .push_i  (push),
    .wdata_i (shift_q),
    .pop_i   (rd_strb),
    .rdata_o (rd_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (rx_count)
  );

  assign rx_valid  = ~fifo_empty;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with CLKS_PER_BIT=16, FIFO_DEPTH_LOG2=3.
// Inputs change on the falling clock edge; outputs are sampled there too.
module tb_uart_rx_fifo;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rxd = 1'b1;
  logic       rd_strb = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rd_data;
  logic       rx_valid;
  logic [3:0] rx_count;
  logic       overrun, frame_err, busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(3)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rxd       (rxd),
    .rd_strb   (rd_strb),
    .clr_err   (clr_err),
    .rd_data   (rd_data),
    .rx_valid  (rx_valid),
    .rx_count  (rx_count),
    .overrun   (overrun),
    .frame_err (frame_err),
    .busy      (busy)
`ifdef UART_RX_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  // Drives one frame; cycle k is driven on the k-th falling edge.
  // par < 0: no parity bit. pop_cyc / rst_cyc < 0: unused.
  // The push of a 10-cell frame lands on the rising edge after cycle 154.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int par,
                            input int pop_cyc, input int rst_cyc);
    logic [10:0] cells;
    int n;
    cells = '1;
    cells[0] = 1'b0;
    cells[8:1] = b;
    if (par >= 0) begin
      cells[9] = par[0];
      cells[10] = stop_bit;
      n = 11;
    end else begin
      cells[9] = stop_bit;
      n = 10;
    end
    for (int cyc = 0; cyc < n * CPB; cyc++) begin
      @(negedge clk);
      rxd = cells[cyc / CPB];
      rd_strb = (cyc == pop_cyc);
      if (cyc == rst_cyc) begin
        resetn = 1'b0;
        rxd = 1'b1;
        rd_strb = 1'b0;
        return;
      end
    end
    @(negedge clk);
    rxd = 1'b1;
    rd_strb = 1'b0;
  endtask

  task automatic pop_once();
    rd_strb = 1'b1;
    @(negedge clk);
    rd_strb = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    total++; if (rx_count !== 4'd0) begin bad++; $display("FAIL reset_rx_count got=%0d exp=0", rx_count); end
    total++; if ({overrun, frame_err, busy} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {overrun, frame_err, busy}); end
  endtask

  task automatic test_single();
    send_frame(8'hA5, 1'b1, -1, -1, -1);
    total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", rx_valid); end
    total++; if (rd_data !== 8'hA5) begin bad++; $display("FAIL single_data got=%h exp=a5", rd_data); end
    total++; if (rx_count !== 4'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", rx_count); end
    pop_once();
    total++; if ({rx_valid, rd_data} !== 9'h000) begin bad++; $display("FAIL single_pop got=%b/%h exp=0/00", rx_valid, rd_data); end
    pop_once();
    total++; if (rx_count !== 4'd0) begin bad++; $display("FAIL pop_empty_count got=%0d exp=0", rx_count); end
  endtask

  task automatic test_glitch();
    int waited;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rxd = 1'b0;
    end
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_seen got=%b exp=1", busy); end
    rxd = 1'b1;
    waited = 0;
    while (busy === 1'b1 && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_clear got=%b exp=0 after %0d cycles", busy, waited); end
    total++; if ({rx_count, frame_err} !== 5'b0) begin bad++; $display("FAIL glitch_no_effect got count=%0d ferr=%b exp 0/0", rx_count, frame_err); end
  endtask

  task automatic test_frame_err();
    send_frame(8'h3C, 1'b0, -1, -1, -1);
    repeat (4) @(negedge clk);
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL ferr_set got=%b exp=1", frame_err); end
    total++; if (rx_count !== 4'd0) begin bad++; $display("FAIL ferr_nopush got=%0d exp=0", rx_count); end
    send_frame(8'h55, 1'b1, -1, -1, -1);
    total++; if (rd_data !== 8'h55 || rx_count !== 4'd1) begin bad++; $display("FAIL ferr_next got=%h/%0d exp=55/1", rd_data, rx_count); end
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL ferr_sticky got=%b exp=1", frame_err); end
    pop_once();
    pulse_clr();
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL ferr_clear got=%b exp=0", frame_err); end
  endtask

  task automatic test_overflow();
    for (int b = 0; b < 9; b++) send_frame(8'(b), 1'b1, -1, -1, -1);
    total++; if (rx_count !== 4'd8) begin bad++; $display("FAIL ovf_count got=%0d exp=8", rx_count); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overrun); end
    for (int b = 0; b < 8; b++) begin
      total++; if (rd_data !== 8'(b)) begin bad++; $display("FAIL ovf_pop%0d got=%h exp=%h", b, rd_data, 8'(b)); end
      pop_once();
    end
    total++; if ({rx_valid, rx_count} !== 5'b0) begin bad++; $display("FAIL ovf_drained got=%b/%0d exp=0/0", rx_valid, rx_count); end
    pulse_clr();
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overrun); end
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 8; b++) send_frame(8'h10 + 8'(b), 1'b1, -1, -1, -1);
    send_frame(8'h18, 1'b1, -1, 154, -1);
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_overrun got=%b exp=0", overrun); end
    total++; if (rx_count !== 4'd8) begin bad++; $display("FAIL b2b_count got=%0d exp=8", rx_count); end
    for (int b = 0; b < 8; b++) begin
      total++; if (rd_data !== 8'h11 + 8'(b)) begin bad++; $display("FAIL b2b_pop%0d got=%h exp=%h", b, rd_data, 8'h11 + 8'(b)); end
      pop_once();
    end
    total++; if (rx_count !== 4'd0) begin bad++; $display("FAIL b2b_drained got=%0d exp=0", rx_count); end
  endtask

  task automatic test_reset_midframe();
    send_frame(8'h42, 1'b1, -1, -1, -1);
    send_frame(8'hFF, 1'b1, -1, -1, 5 * CPB + CPB / 2);
    #1;
    total++; if ({rx_valid, rd_data} !== 9'h000) begin bad++; $display("FAIL rst_mid_data got=%b/%h exp=0/00", rx_valid, rd_data); end
    total++; if (rx_count !== 4'd0) begin bad++; $display("FAIL rst_mid_count got=%0d exp=0", rx_count); end
    total++; if ({overrun, frame_err, busy} !== 3'b000) begin bad++; $display("FAIL rst_mid_flags got=%b exp=000", {overrun, frame_err, busy}); end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    send_frame(8'h81, 1'b1, -1, -1, -1);
    total++; if (rd_data !== 8'h81 || rx_count !== 4'd1) begin bad++; $display("FAIL rst_mid_next got=%h/%0d exp=81/1", rd_data, rx_count); end
    pop_once();
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    send_frame(8'h07, 1'b1, 1, -1, -1);
    total++; if (rd_data !== 8'h07 || rx_count !== 4'd1) begin bad++; $display("FAIL par_good got=%h/%0d exp=07/1", rd_data, rx_count); end
    total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL par_good_flag got=%b exp=0", parity_err); end
    pop_once();
    send_frame(8'h07, 1'b1, 0, -1, -1);
    total++; if (parity_err !== 1'b1) begin bad++; $display("FAIL par_bad_flag got=%b exp=1", parity_err); end
    total++; if (rx_count !== 4'd0) begin bad++; $display("FAIL par_bad_nopush got=%0d exp=0", rx_count); end
    pulse_clr();
    total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL par_clear got=%b exp=0", parity_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_overflow();
    test_back_to_back();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receiver for the SOC IO page, driven from the RXD pin. Shares the 115200 8N1 framing of the existing transmitter.
- Oversamples the line, deserialises bytes LSB-first and pushes each good byte into a small FIFO.
- The CPU reads the FIFO head and status through the IO read mux. A read strobe pops the FIFO.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per bit period (100 MHz / 115200); must be >= 4
- FIFO_DEPTH_LOG2, 3, FIFO holds 2^FIFO_DEPTH_LOG2 bytes (default 8)

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- rxd  in  1  raw serial line, idle high, asynchronous to clk
- rd_strb  in  1  pop FIFO head (CPU read of the RX data word)
- clr_err  in  1  clear sticky error flags
- rd_data  out  8  FIFO head byte, first-word-fall-through; 0 when empty
- rx_valid  out  1  FIFO not empty
- rx_count  out  FIFO_DEPTH_LOG2+1  bytes currently held
- overrun  out  1  sticky: byte dropped because FIFO was full
- frame_err  out  1  sticky: stop bit sampled low
- busy  out  1  receiver FSM not in IDLE

Behaviour:
- Reset:
  - Asynchronous, active-low.
  - Outputs after reset: rd_data=0, rx_valid=0, rx_count=0, overrun=0, frame_err=0, busy=0.
  - Synchroniser flops reset to 1. FSM goes to IDLE; pointers and counters clear.
  - Reset asserted mid-frame abandons the frame with no push.
- Input path:
  - rxd passes through a 2-flop synchroniser and then an edge-detect flop (rxs = synchronised level).
  - Internal latency from pin to rxs is 2 cycles.
- FSM states: IDLE, START, DATA, STOP, plus PARITY when the optional feature is enabled. A bit counter runs from 0 to CLKS_PER_BIT-1.
- IDLE:
  - A falling edge on rxs goes to START and loads the counter for a half-bit wait, (CLKS_PER_BIT/2)-1.
- START:
  - At the half-bit point, rxs=0 goes to DATA with bit index 0.
  - rxs=1 is a false start: return to IDLE with no flags set.
- DATA:
  - Samples every CLKS_PER_BIT cycles at bit centre and shifts into the shift register LSB-first.
  - After bit 7 goes to STOP, or to PARITY when enabled.
- STOP: one bit period later, sample rxs.
  - rxs=1: push the byte and return to IDLE.
  - rxs=0: set frame_err, no push. Wait until rxs=1, then return to IDLE; a break condition does not retrigger.
- FIFO:
  - Circular buffer with FIFO_DEPTH_LOG2+1-bit pointers; pointers wrap modulo 2^(FIFO_DEPTH_LOG2+1).
  - Full when the pointer MSBs differ and the low bits are equal.
  - A pushed byte is visible on rd_data and rx_valid the cycle after the push.
- FIFO boundary rules:
  - Pop while empty is ignored; count and pointers stay unchanged.
  - Push while full drops the byte and sets overrun.
  - Push and pop in the same cycle while full: pop first, the push is accepted and overrun stays clear. rx_count is unchanged.
  - Push and pop in the same cycle while empty: only the push takes effect.
- Errors: overrun and frame_err are sticky. clr_err clears both. If a set and a clear occur in the same cycle, set wins.
- busy is high whenever the FSM is not in IDLE.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - The frame is 8E1. The PARITY state samples one extra bit after bit 7.
  - On a mismatch against even parity of the data, set sticky output parity_err and do not push the byte.
  - The STOP check still runs.
  - parity_err resets to 0 and clears on clr_err.
- Not defined: 8N1; the parity_err port and the PARITY state do not exist.

Decomposition:
- Shared package/header holds:
  - FSM state encodings
  - IO_UART_RX_DAT and IO_UART_RX_STAT word-address bit indices, extending the existing IO_* bit map
  - the default CLKS_PER_BIT constant
- One natural sub-module: sync_fifo, a generic width/depth FWFT FIFO with push, pop, full, empty and count. uart_rx_fifo instantiates it at width 8.
- SOC IO read mux: the status word packs rx_valid, overrun, frame_err and rx_count.

Test Plan:
- All tests use CLKS_PER_BIT=16 and FIFO_DEPTH_LOG2=3.
- Send 0xA5 8N1: rx_valid rises, rd_data=0xA5, rx_count=1. rd_strb for 1 cycle: rx_valid=0, rd_data=0.
- Low glitch of 4 cycles on an idle line: no push, busy returns to 0 within 8 cycles after the glitch, frame_err=0.
- Send 0x3C with the stop bit held low, then release: frame_err=1, rx_count=0. Next 0x55 received correctly. clr_err leaves frame_err=0.
- Send 9 bytes 0x00..0x08 with no pops: rx_count=8, overrun=1, pops return 0x00..0x07.
  - Repeat with the FIFO full and rd_strb coincident with the 9th push: overrun=0, head advances.
- Assert resetn=0 at data bit 4 of 0xFF: all outputs 0 immediately. After release, 0x81 received correctly.
- With UART_RX_PARITY_EN defined:
  - Send 0x07 with parity bit 1: received correctly.
  - Send 0x07 with parity bit 0: parity_err=1 and no push.
